// File: rtl/xnor_popcount_acc.sv
// XNOR-popcount accumulator for one binary MLP neuron, producing its sum and thresholded activation.
// Optional macro XNOR_BIPOLAR_SUM_EN: signed bipolar dot product output and signed threshold compare.
module xnor_popcount_acc #(
  parameter int WORD_W  = 16,
  parameter int N_BEATS = 49,
  parameter int SUM_W   = 15
) (
  input  logic              gated_clk,
  input  logic              rst7,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] act,
  input  logic [WORD_W-1:0] wgt,
  input  logic [SUM_W-1:0]  threshold,
  output logic              sum_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  sum_out,
  output logic              bin_out,
  output logic              busy
);

  localparam int POP_W = $clog2(WORD_W + 1);
  localparam int CNT_W = $clog2(N_BEATS + 1);
  localparam int ADD_W = ((SUM_W > POP_W) ? SUM_W : POP_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [SUM_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [SUM_W-1:0]   r_sum;
  logic               r_bin;

  logic [POP_W-1:0]   w_pop;
  logic [ADD_W-1:0]   w_add;
  logic [SUM_W-1:0]   w_acc_next;
  logic [SUM_W-1:0]   w_result;
  logic               w_bin;
  logic               w_beat;
  logic               w_last;

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      w_pop = w_pop + POP_W'(~(act[i] ^ wgt[i]));
    end
  end

  // Widened add so any carry out of SUM_W bits is seen and clamped instead of wrapping.
  assign w_add      = ADD_W'(r_acc) + ADD_W'(w_pop);
  assign w_acc_next = (|w_add[ADD_W-1:SUM_W]) ? '1 : w_add[SUM_W-1:0];
  assign w_beat     = (r_state == S_ACC) && in_valid;
  assign w_last     = (r_cnt == CNT_W'(N_BEATS - 1));

`ifdef XNOR_BIPOLAR_SUM_EN
  localparam logic signed [63:0] S_MAX = (64'sd1 <<< (SUM_W - 1)) - 64'sd1;
  localparam logic signed [63:0] S_MIN = -(64'sd1 <<< (SUM_W - 1));
  logic signed [63:0] w_bip;

  // Each match contributes +1 and each mismatch -1, so the dot product is 2*matches - total.
  assign w_bip = $signed(64'(w_acc_next) <<< 1) - 64'sd1 * (N_BEATS * WORD_W);

  always_comb begin
    if (w_bip > S_MAX) begin
      w_result = S_MAX[SUM_W-1:0];
    end else if (w_bip < S_MIN) begin
      w_result = S_MIN[SUM_W-1:0];
    end else begin
      w_result = w_bip[SUM_W-1:0];
    end
  end

  assign w_bin = ($signed(w_result) >= $signed(threshold));
`else
  assign w_result = w_acc_next;
  assign w_bin    = (w_acc_next >= threshold);
`endif

  always_ff @(posedge gated_clk or negedge rst7) begin
    if (!rst7) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)           w_state_next = S_ACC;
      S_ACC:   if (w_beat && w_last) w_state_next = S_DONE;
      S_DONE:  if (out_ready)       w_state_next = S_IDLE;
      default:                      w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    sum_valid = 1'b0;
    case (r_state)
      S_ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        busy      = 1'b1;
        sum_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge gated_clk or negedge rst7) begin
    if (!rst7) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sum <= '0;
      r_bin <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_beat) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum <= w_result;
        r_bin <= w_bin;
      end
    end
  end

  assign sum_out = r_sum;
  assign bin_out = r_bin;

endmodule

// File: tb/tb_xnor_popcount_acc.sv
// Directed bench for xnor_popcount_acc: vector table plus hold, mid-run reset and saturation sequences.
module tb_xnor_popcount_acc;

  logic        gated_clk = 1'b0;
  logic        rst7;
  logic        start, in_valid, out_ready;
  logic [15:0] act, wgt;
  logic [14:0] threshold;
  logic        in_ready, sum_valid, bin_out, busy;
  logic [14:0] sum_out;

  logic        s_start, s_in_valid, s_out_ready;
  logic [15:0] s_act, s_wgt;
  logic [5:0]  s_threshold;
  logic        s_in_ready, s_sum_valid, s_bin_out, s_busy;
  logic [5:0]  s_sum_out;

  int total = 0;
  int bad   = 0;

  always #5 gated_clk = ~gated_clk;

  xnor_popcount_acc #(.WORD_W(16), .N_BEATS(4), .SUM_W(15)) dut (
    .gated_clk(gated_clk), .rst7(rst7), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .act(act), .wgt(wgt), .threshold(threshold),
    .sum_valid(sum_valid), .out_ready(out_ready), .sum_out(sum_out),
    .bin_out(bin_out), .busy(busy)
  );

  xnor_popcount_acc #(.WORD_W(16), .N_BEATS(8), .SUM_W(6)) dut_s (
    .gated_clk(gated_clk), .rst7(rst7), .start(s_start), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .act(s_act), .wgt(s_wgt), .threshold(s_threshold),
    .sum_valid(s_sum_valid), .out_ready(s_out_ready), .sum_out(s_sum_out),
    .bin_out(s_bin_out), .busy(s_busy)
  );

  typedef struct {
    logic [3:0][15:0] a;
    logic [3:0][15:0] w;
    logic [14:0]      th;
    int               raw;
    int               gap;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gated_clk);
    #1;
  endtask

  // Expected output for the 4-beat, 16-bit, 15-bit-sum configuration.
  function automatic logic [14:0] m_sum(input int raw);
`ifdef XNOR_BIPOLAR_SUM_EN
    int v;
    v = 2 * raw - 64;
    if (v > 16383)  v = 16383;
    if (v < -16384) v = -16384;
    return v[14:0];
`else
    return raw[14:0];
`endif
  endfunction

  function automatic logic m_bin(input logic [14:0] s, input logic [14:0] th);
`ifdef XNOR_BIPOLAR_SUM_EN
    return $signed(s) >= $signed(th);
`else
    return s >= th;
`endif
  endfunction

  task automatic run_eval(input logic [3:0][15:0] a, input logic [3:0][15:0] w,
                          input logic [14:0] th, input int gap, input string tag);
    threshold = th;
    chk({tag, "_idle_rdy"}, in_ready, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_acc_rdy"}, in_ready, 1'b1);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        tick();
      end
      act = a[b];
      wgt = w[b];
      in_valid = 1'b1;
      chk($sformatf("%s_novalid_b%0d", tag, b), sum_valid, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    chk({tag, "_valid"}, sum_valid, 1'b1);
    chk({tag, "_done_rdy"}, in_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_released"}, sum_valid, 1'b0);
    chk({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [14:0] hold_sum;
    logic        hold_bin;
    logic [5:0]  s_exp;
    logic        s_exp_bin;

    rst7 = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    act = '0; wgt = '0; threshold = '0;
    s_start = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    s_act = '0; s_wgt = '0; s_threshold = '0;

    vecs[0] = '{a: {4{16'hFFFF}}, w: {4{16'hFFFF}}, th: 15'd64, raw: 64, gap: 0};
    vecs[1] = '{a: {4{16'hFFFF}}, w: {4{16'hFFFF}}, th: 15'd65, raw: 64, gap: 0};
    vecs[2] = '{a: {4{16'hFFFF}}, w: {4{16'h0000}}, th: 15'd0,  raw: 0,  gap: 3};
    vecs[3] = '{a: {16'hFFFF, 16'h00FF, 16'hA5A5, 16'h1234},
                w: {16'h0000, 16'h00FF, 16'h5A5A, 16'h1234}, th: 15'd32, raw: 32, gap: 1};
    vecs[4] = '{a: {4{16'h3C3C}}, w: {4{16'hC3C3}}, th: 15'h7FFF, raw: 0, gap: 0};
    vecs[5] = '{a: {16'h8000, 16'hAAAA, 16'h0001, 16'h00F0},
                w: {16'h0001, 16'hAAAA, 16'h0000, 16'h0F00}, th: 15'd53, raw: 53, gap: 2};

    repeat (2) tick();
    chk("rst_sum", sum_out, '0);
    chk("rst_bin", bin_out, 1'b0);
    chk("rst_valid", sum_valid, 1'b0);
    chk("rst_rdy", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst7 = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_eval(vecs[i].a, vecs[i].w, vecs[i].th, vecs[i].gap, $sformatf("v%0d", i));
      chk($sformatf("v%0d_sum", i), sum_out, m_sum(vecs[i].raw));
      chk($sformatf("v%0d_bin", i), bin_out, m_bin(m_sum(vecs[i].raw), vecs[i].th));
      release_result($sformatf("v%0d", i));
      tick();
    end

    // Result held in DONE while start and in_valid toggle.
    run_eval(vecs[5].a, vecs[5].w, vecs[5].th, 0, "hold");
    hold_sum = sum_out;
    hold_bin = bin_out;
    chk("hold_sum0", hold_sum, m_sum(53));
    for (int c = 0; c < 10; c++) begin
      start    = c[0];
      in_valid = ~c[0];
      act      = 16'hFFFF;
      wgt      = 16'hFFFF;
      tick();
      chk($sformatf("hold_sum_c%0d", c), sum_out, m_sum(53));
      chk($sformatf("hold_bin_c%0d", c), bin_out, m_bin(m_sum(53), 15'd53));
      chk($sformatf("hold_valid_c%0d", c), sum_valid, 1'b1);
      chk($sformatf("hold_rdy_c%0d", c), in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    chk("hold_release_valid", sum_valid, 1'b0);
    chk("hold_start_ignored", in_ready, 1'b0);
    tick();
    chk("hold_still_idle", busy, 1'b0);
    chk("hold_sum_kept", sum_out, m_sum(53));

    // Asynchronous reset partway through an evaluation.
    start = 1'b1;
    tick();
    start = 1'b0;
    act = 16'hFFFF; wgt = 16'hFFFF; in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    #2 rst7 = 1'b0;
    #1;
    chk("arst_sum", sum_out, '0);
    chk("arst_bin", bin_out, 1'b0);
    chk("arst_valid", sum_valid, 1'b0);
    chk("arst_rdy", in_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    #2 rst7 = 1'b1;
    tick();
    run_eval({4{16'h00FF}}, {4{16'h00FF}}, 15'd64, 0, "post");
    chk("post_sum", sum_out, m_sum(64));
    chk("post_bin", bin_out, m_bin(m_sum(64), 15'd64));
    release_result("post");

    // Narrow accumulator: 8 all-match beats (128) must clamp, not wrap.
`ifdef XNOR_BIPOLAR_SUM_EN
    s_exp     = 6'h3E;
    s_exp_bin = 1'b0;
`else
    s_exp     = 6'd63;
    s_exp_bin = 1'b1;
`endif
    s_threshold = 6'h3F;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_act = 16'hFFFF; s_wgt = 16'hFFFF;
    for (int b = 0; b < 8; b++) begin
      s_in_valid = 1'b1;
      chk($sformatf("sat_novalid_b%0d", b), s_sum_valid, 1'b0);
      tick();
    end
    s_in_valid = 1'b0;
    chk("sat_valid", s_sum_valid, 1'b1);
    chk("sat_sum", s_sum_out, s_exp);
    chk("sat_bin", s_bin_out, s_exp_bin);
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
    chk("sat_released", s_sum_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
